vga_sincronismo: RTL



---
 rtl/vga_pkg.sv | 26 ++
 rtl/contador_mod.sv | 27 ++
 rtl/vga_sincronismo.sv | 89 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants for the sync generator and the pixel renderer.
package vga_pkg;

  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;

  localparam int H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_VISIBLE_DEF + V_FRONT_DEF;

  // Visible window in raw counter coordinates; the renderer subtracts X_INI/Y_INI.
  localparam int X_INI = H_SYNC_DEF + H_BACK_DEF;
  localparam int X_FIM = X_INI + H_VISIBLE_DEF - 1;
  localparam int Y_INI = V_SYNC_DEF + V_BACK_DEF;
  localparam int Y_FIM = Y_INI + V_VISIBLE_DEF - 1;

  function automatic logic dentro(input logic [9:0] v, input int lo, input int hi);
    return (v >= 10'(lo)) && (v <= 10'(hi));
  endfunction

endpackage

// File: rtl/contador_mod.sv
// Modulo-N up counter with enable; exposes its next value so callers can decode ahead.
module contador_mod #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] valor,
  output logic [W-1:0] valor_prox,
  output logic         terminal
);

  // Terminal compare happens before the increment so the count never passes N-1.
  assign terminal = (valor == W'(N - 1));

  always_comb begin
    valor_prox = valor;
    if (en) valor_prox = terminal ? '0 : valor + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valor <= '0;
    else        valor <= valor_prox;
  end

endmodule

// File: rtl/vga_sincronismo.sv
// VGA timing generator: CLOCK_50/2 pixel clock, X/Y counters, registered syncs, blanking and frame tick.
module vga_sincronismo
  import vga_pkg::*;
#(
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] VGA_X,
  output logic [9:0] VGA_Y,
  output logic       fim_quadro,
  output logic [7:0] contador_quadros
);

  localparam int H_TOT  = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOT  = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int X_PRIM = H_SYNC + H_BACK;
  localparam int X_ULT  = X_PRIM + H_VISIBLE - 1;
  localparam int Y_PRIM = V_SYNC + V_BACK;
  localparam int Y_ULT  = Y_PRIM + V_VISIBLE - 1;

  logic       fase;
  logic       pix_en;
  logic       h_term;
  logic       v_term;
  logic       v_en;
  logic       inicio_fp;
  logic [9:0] x_prox;
  logic [9:0] y_prox;

  // Counters step on the edge where VGA_CLK falls, leaving them stable at its rising edge.
  assign pix_en = fase;
  assign v_en   = h_term & pix_en;

  contador_mod #(.N(H_TOT), .W(10)) u_cont_h (
    .clk        (CLOCK_50),
    .rst_n      (reset),
    .en         (pix_en),
    .valor      (VGA_X),
    .valor_prox (x_prox),
    .terminal   (h_term)
  );

  contador_mod #(.N(V_TOT), .W(10)) u_cont_v (
    .clk        (CLOCK_50),
    .rst_n      (reset),
    .en         (v_en),
    .valor      (VGA_Y),
    .valor_prox (y_prox),
    .terminal   (v_term)
  );

  // Frame tick marks entry into the vertical front porch, so it never fires on the (0,0) wrap.
  assign inicio_fp  = v_en && (y_prox == 10'(Y_ULT + 1));
  assign VGA_SYNC_N = 1'b0;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      fase             <= 1'b0;
      VGA_CLK          <= 1'b0;
      VGA_HS           <= 1'b0;
      VGA_VS           <= 1'b0;
      VGA_BLANK_N      <= 1'b0;
      fim_quadro       <= 1'b0;
      contador_quadros <= '0;
    end else begin
      fase        <= ~fase;
      VGA_CLK     <= ~fase;
      VGA_HS      <= (x_prox >= 10'(H_SYNC));
      VGA_VS      <= (y_prox >= 10'(V_SYNC));
      VGA_BLANK_N <= dentro(x_prox, X_PRIM, X_ULT) && dentro(y_prox, Y_PRIM, Y_ULT);
      fim_quadro  <= inicio_fp;
      if (inicio_fp) contador_quadros <= contador_quadros + 8'd1;
    end
  end

endmodule
